// File: rtl/imem_loader.sv
// imem_loader: 256 x 16 instruction memory with a combinational fetch port and a
// byte-stream loader that writes programs while the core is halted.
// Optional build macro IMEM_CLEAR_EN: after reset, sweep the whole array to zero
// (CLR state, 256 cycles) before the loader accepts a session.
module imem_loader #(
  parameter int unsigned DEPTH = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        state,
  input  logic [7:0]  i_addr,
  output logic [15:0] i_datain,
  input  logic        ld_start,
  input  logic [7:0]  ld_addr,
  input  logic        ld_valid,
  input  logic [7:0]  ld_data,
  input  logic        ld_last,
  output logic        ld_ready,
  output logic        ld_busy,
  output logic        ld_done,
  output logic        ld_err,
  output logic [8:0]  ld_count
);

  // Core run-state encodings, matching the core's define.v.
  localparam logic CoreIdle = 1'b0;
  localparam logic CoreExec = 1'b1;

  localparam logic [1:0] FsmIdle = 2'd0;
  localparam logic [1:0] FsmHi   = 2'd1;
  localparam logic [1:0] FsmLo   = 2'd2;
`ifdef IMEM_CLEAR_EN
  localparam logic [1:0] FsmClr  = 2'd3;
  localparam logic [1:0] FsmRst  = FsmClr;
`else
  localparam logic [1:0] FsmRst  = FsmIdle;
`endif

  logic [1:0]  fsm_q, fsm_d;
  logic [7:0]  wptr_q, wptr_d;
  logic [7:0]  hi_q, hi_d;
  logic [8:0]  count_q, count_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic        xfer;

  logic [15:0] mem_q [DEPTH];

  assign ld_ready = ((fsm_q == FsmHi) || (fsm_q == FsmLo)) && (state == CoreIdle);
  assign ld_busy  = (fsm_q != FsmIdle);
  assign ld_done  = done_q;
  assign ld_err   = err_q;
  assign ld_count = count_q;
  assign xfer     = ld_valid && ld_ready;

  // Fetch read is purely combinational and ignores the loader FSM.
  assign i_datain = mem_q[i_addr];

  // Loader FSM next-state, write strobe and pulse generation.
  always_comb begin
    fsm_d     = fsm_q;
    wptr_d    = wptr_q;
    hi_d      = hi_q;
    count_d   = count_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = {hi_q, ld_data};
    case (fsm_q)
      FsmIdle: begin
        if (ld_start && (state == CoreIdle)) begin
          wptr_d  = ld_addr;
          count_d = 9'd0;
          fsm_d   = FsmHi;
        end
      end
      FsmHi: begin
        if (state == CoreExec) begin
          fsm_d = FsmIdle;
          err_d = 1'b1;
        end else if (xfer) begin
          if (ld_last) begin
            // A lone high byte cannot form a word: drop it and flag the session.
            fsm_d = FsmIdle;
            err_d = 1'b1;
          end else begin
            hi_d  = ld_data;
            fsm_d = FsmLo;
          end
        end
      end
      FsmLo: begin
        if (state == CoreExec) begin
          fsm_d = FsmIdle;
          err_d = 1'b1;
        end else if (xfer) begin
          mem_we  = 1'b1;
          wptr_d  = wptr_q + 8'd1;
          count_d = (count_q == 9'd256) ? count_q : count_q + 9'd1;
          fsm_d   = ld_last ? FsmIdle : FsmHi;
          done_d  = ld_last;
        end
      end
`ifdef IMEM_CLEAR_EN
      FsmClr: begin
        // wptr doubles as the sweep address; it wraps back to 0 on exit.
        mem_we    = 1'b1;
        mem_wdata = 16'h0000;
        wptr_d    = wptr_q + 8'd1;
        if (wptr_q == 8'hFF) begin
          fsm_d = FsmIdle;
        end
      end
`endif
      default: fsm_d = FsmIdle;
    endcase
  end

  // Loader state registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fsm_q   <= FsmRst;
      wptr_q  <= 8'd0;
      hi_q    <= 8'd0;
      count_q <= 9'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      wptr_q  <= wptr_d;
      hi_q    <= hi_d;
      count_q <= count_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Array write port; contents survive reset.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem_q[wptr_q] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: scoreboard of expected words built while
// bytes are driven, compared through the fetch port once each session ends.
module tb_imem_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        state = 1'b0;
  logic [7:0]  i_addr = 8'd0;
  logic [15:0] i_datain;
  logic        ld_start = 1'b0;
  logic [7:0]  ld_addr = 8'd0;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_data = 8'd0;
  logic        ld_last = 1'b0;
  logic        ld_ready;
  logic        ld_busy;
  logic        ld_done;
  logic        ld_err;
  logic [8:0]  ld_count;

  imem_loader #(.DEPTH(256)) dut (
    .clock    (clock),
    .reset    (reset),
    .state    (state),
    .i_addr   (i_addr),
    .i_datain (i_datain),
    .ld_start (ld_start),
    .ld_addr  (ld_addr),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .ld_last  (ld_last),
    .ld_ready (ld_ready),
    .ld_busy  (ld_busy),
    .ld_done  (ld_done),
    .ld_err   (ld_err),
    .ld_count (ld_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0]  a;
    logic [15:0] w;
  } exp_t;

  exp_t sb[$];

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  // Reference model of the loader datapath.
  logic [7:0] m_wptr = 8'd0;
  logic [7:0] m_hi = 8'd0;
  logic       m_lo = 1'b0;
  int         m_count = 0;

`ifdef IMEM_CLEAR_EN
  localparam logic BusyAfterReset = 1'b1;
`else
  localparam logic BusyAfterReset = 1'b0;
`endif

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start(input logic [7:0] a);
    ld_start = 1'b1;
    ld_addr  = a;
    tick();
    ld_start = 1'b0;
    m_wptr   = a;
    m_count  = 0;
    m_lo     = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    int n;
    n = 0;
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    while (!ld_ready && n < 20) begin
      tick();
      n++;
    end
    if (!ld_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout got=%b want=1", ld_ready);
    end else if (!m_lo) begin
      if (!last) begin
        m_hi = d;
        m_lo = 1'b1;
      end
    end else begin
      sb.push_back('{a: m_wptr, w: {m_hi, d}});
      m_wptr  = m_wptr + 8'd1;
      m_count = (m_count == 256) ? 256 : m_count + 1;
      m_lo    = 1'b0;
    end
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    if (ld_done) done_cnt++;
    if (ld_err) err_cnt++;
  endtask

  task automatic check_sb(input string name);
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      i_addr = e.a;
      #1;
      checks++;
      if (i_datain !== e.w) begin
        errors++;
        $display("FAIL %s mem[%02h] got=%04h want=%04h", name, e.a, i_datain, e.w);
      end
    end
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if (ld_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got=%b want=0", ld_ready); end
    checks++;
    if (ld_busy !== BusyAfterReset) begin
      errors++; $display("FAIL rst_busy got=%b want=%b", ld_busy, BusyAfterReset);
    end
    checks++;
    if (ld_done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b want=0", ld_done); end
    checks++;
    if (ld_err !== 1'b0) begin errors++; $display("FAIL rst_err got=%b want=0", ld_err); end
    checks++;
    if (ld_count !== 9'd0) begin errors++; $display("FAIL rst_count got=%0d want=0", ld_count); end
    reset = 1'b1;
`ifdef IMEM_CLEAR_EN
    n = 0;
    while (ld_busy && n < 400) begin
      tick();
      n++;
    end
    checks++;
    if (n != 256) begin errors++; $display("FAIL clr_cycles got=%0d want=256", n); end
    for (int a = 0; a < 256; a++) begin
      i_addr = a[7:0];
      #1;
      checks++;
      if (i_datain !== 16'h0000) begin
        errors++; $display("FAIL clr_zero mem[%02h] got=%04h want=0000", a[7:0], i_datain);
      end
    end
`else
    n = 0;
`endif
    tick();
  endtask

  task automatic test_basic();
    done_cnt = 0;
    err_cnt  = 0;
    start(8'h10);
    checks++;
    if (ld_busy !== 1'b1) begin errors++; $display("FAIL basic_busy got=%b want=1", ld_busy); end
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'hAB, 1'b0);
    send_byte(8'hCD, 1'b1);
    checks++;
    if (ld_done !== 1'b1) begin errors++; $display("FAIL basic_done got=%b want=1", ld_done); end
    checks++;
    if (ld_count !== 9'd2) begin errors++; $display("FAIL basic_count got=%0d want=2", ld_count); end
    tick();
    checks++;
    if (ld_done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got=%b want=0", ld_done); end
    checks++;
    if (done_cnt != 1 || err_cnt != 0) begin
      errors++; $display("FAIL basic_pulses got=%0d/%0d want=1/0", done_cnt, err_cnt);
    end
    i_addr = 8'h10;
    #1;
    checks++;
    if (i_datain !== 16'h1234) begin
      errors++; $display("FAIL basic_fetch got=%04h want=1234", i_datain);
    end
    check_sb("basic");
  endtask

  task automatic test_wrap();
    start(8'hFF);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b1);
    checks++;
    if (ld_count !== 9'd2) begin errors++; $display("FAIL wrap_count got=%0d want=2", ld_count); end
    i_addr = 8'h00;
    #1;
    checks++;
    if (i_datain !== 16'h3344) begin
      errors++; $display("FAIL wrap_addr0 got=%04h want=3344", i_datain);
    end
    check_sb("wrap");
    tick();
  endtask

  task automatic test_hi_last();
    start(8'h40);
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    send_byte(8'h77, 1'b1);
    checks++;
    if (ld_err !== 1'b1 || ld_done !== 1'b0) begin
      errors++; $display("FAIL hilast_err got=%b/%b want=1/0", ld_err, ld_done);
    end
    checks++;
    if (ld_busy !== 1'b0) begin errors++; $display("FAIL hilast_idle got=%b want=0", ld_busy); end
    checks++;
    if (ld_count !== m_count[8:0]) begin
      errors++; $display("FAIL hilast_count got=%0d want=%0d", ld_count, m_count);
    end
    check_sb("hilast");
    tick();
  endtask

  task automatic test_abort();
    start(8'h50);
    send_byte(8'h9A, 1'b0);
    send_byte(8'hBC, 1'b0);
    send_byte(8'hDE, 1'b0);
    state = 1'b1;
    #1;
    checks++;
    if (ld_ready !== 1'b0) begin errors++; $display("FAIL abort_ready got=%b want=0", ld_ready); end
    tick();
    m_lo = 1'b0;
    checks++;
    if (ld_err !== 1'b1 || ld_done !== 1'b0) begin
      errors++; $display("FAIL abort_err got=%b/%b want=1/0", ld_err, ld_done);
    end
    ld_start = 1'b1;
    ld_addr  = 8'h99;
    tick();
    ld_start = 1'b0;
    checks++;
    if (ld_err !== 1'b0) begin errors++; $display("FAIL abort_err_pulse got=%b want=0", ld_err); end
    checks++;
    if (ld_busy !== 1'b0) begin errors++; $display("FAIL abort_start_ignored got=%b want=0", ld_busy); end
    state = 1'b0;
    tick();
    checks++;
    if (ld_count !== 9'd1) begin errors++; $display("FAIL abort_count got=%0d want=1", ld_count); end
    check_sb("abort");
  endtask

  task automatic test_stall();
    start(8'h60);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (ld_count !== 9'd1 || ld_ready !== 1'b1) begin
        errors++; $display("FAIL stall_hold got=%0d/%b want=1/1", ld_count, ld_ready);
      end
    end
    send_byte(8'h03, 1'b0);
    send_byte(8'h04, 1'b1);
    checks++;
    if (ld_done !== 1'b1 || ld_count !== 9'd2) begin
      errors++; $display("FAIL stall_end got=%b/%0d want=1/2", ld_done, ld_count);
    end
    check_sb("stall");
    tick();
  endtask

  task automatic test_back_to_back();
    start(8'h10);
    send_byte(8'hCA, 1'b0);
    i_addr   = 8'h10;
    ld_valid = 1'b1;
    ld_data  = 8'hFE;
    ld_last  = 1'b1;
    #1;
    checks++;
    if (ld_ready !== 1'b1 || i_datain !== 16'h1234) begin
      errors++; $display("FAIL b2b_old_read got=%b/%04h want=1/1234", ld_ready, i_datain);
    end
    send_byte(8'hFE, 1'b1);
    checks++;
    if (i_datain !== 16'hCAFE || ld_done !== 1'b1) begin
      errors++; $display("FAIL b2b_new_read got=%04h/%b want=cafe/1", i_datain, ld_done);
    end
    check_sb("b2b");
    tick();
  endtask

  task automatic test_reset_mid();
    int n;
    start(8'h70);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (ld_busy !== BusyAfterReset || ld_ready !== 1'b0 || ld_count !== 9'd0) begin
      errors++;
      $display("FAIL midrst got=%b/%b/%0d want=%b/0/0", ld_busy, ld_ready, ld_count,
               BusyAfterReset);
    end
    tick();
    reset = 1'b1;
`ifdef IMEM_CLEAR_EN
    n = 0;
    while (ld_busy && n < 400) begin
      tick();
      n++;
    end
    sb.delete();
    sb.push_back('{a: 8'h70, w: 16'h0000});
`else
    n = 0;
`endif
    check_sb("midrst");
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_hi_last();
    test_abort();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
